i2c_pointer_arbiter: RTL and testbench

I2C_POINTER_ARBITER -- requirements
Module: i2c_pointer_arbiter

---
 rtl/i2c_pointer_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_i2c_pointer_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_pointer_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_pointer_arbiter
//
// Shares one I2C pointer-write engine among four requesters. Arbitration is
// round-robin, starting one past the last requester served. The winner's slave
// address and register pointer are registered onto ENG_SLAVE/ENG_POINTER.
// ENG_GO is then pulsed for GO_HOLD cycles. The engine handshake is tracked
// through ENG_END_OK: it falls when the engine starts and rises when it ends.
// The transaction closes with a one-cycle, one-hot DONE pulse that carries the
// ACK and ERR status.
//
// Optional feature: define I2C_ARB_TIMEOUT_EN to compile in a watchdog. The
// watchdog bounds each wait state to TIMEOUT_CYC cycles. On expiry, it ends
// the transaction with ERR=1 and ACK=0. When the macro is not defined, ERR is
// tied low and the block waits for the engine indefinitely.
//
// Parameters:
//   GO_HOLD      cycles ENG_GO is held high (1..255)
//   TIMEOUT_CYC  wait-state cycle limit (16-bit), used by the watchdog only
//
// Ports:
//   PT_CK        clock, shared with the pointer-write engine
//   RESET_N      asynchronous active-low reset
//   REQ[3:0]     level request per requester, held until its DONE
//   REQ_SLAVE    slave address for requester n in bits [8n+7:8n]
//   REQ_POINTER  register pointer for requester n in bits [8n+7:8n]
//   DONE[3:0]    one-cycle completion pulse, one-hot per requester
//   ACK          engine ACK_OK captured at completion
//   ERR          timeout flag
//   GRANT[3:0]   one-hot current engine owner, zero when idle
//   ENG_GO       engine GO
//   ENG_SLAVE    engine SLAVE_ADDRESS
//   ENG_POINTER  engine POINTER
//   ENG_END_OK   engine idle/finished status
//   ENG_ACK_OK   engine acknowledge status
// ---------------------------------------------------------------------------
module i2c_pointer_arbiter #(
    parameter int GO_HOLD     = 4,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic        PT_CK,
    input  logic        RESET_N,
    input  logic [3:0]  REQ,
    input  logic [31:0] REQ_SLAVE,
    input  logic [31:0] REQ_POINTER,
    output logic [3:0]  DONE,
    output logic        ACK,
    output logic        ERR,
    output logic [3:0]  GRANT,
    output logic        ENG_GO,
    output logic [7:0]  ENG_SLAVE,
    output logic [7:0]  ENG_POINTER,
    input  logic        ENG_END_OK,
    input  logic        ENG_ACK_OK
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GO_HI     = 3'd1,
        ST_GO_LO     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_END  = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    localparam logic [7:0] GO_HOLD_C = 8'(GO_HOLD);

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  rr_q, rr_d;
    logic [7:0]  slave_q, slave_d;
    logic [7:0]  pointer_q, pointer_d;
    logic [7:0]  go_cnt_q, go_cnt_d;
    logic        eng_go_q, eng_go_d;
    logic [3:0]  done_q, done_d;
    logic        ack_q, ack_d;

    logic        pick_valid_s;
    logic [1:0]  pick_idx_s;
    logic [1:0]  cand_s;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_CYC);
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic        expire_s;
`endif

    // Round-robin pick: scan from rr_q upward; the descending loop lets the
    // lowest offset from rr_q win.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = 2'd0;
        cand_s       = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            cand_s = rr_q + 2'(i);
            if (REQ[cand_s]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog expiry: this is the cycle in which the counter would reach the limit.
    always_comb begin
        expire_s = ((wait_cnt_q + 16'd1) == TIMEOUT_C);
    end
`endif

    // Next-state and registered-output logic for the arbitration FSM.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        rr_d      = rr_q;
        slave_d   = slave_q;
        pointer_d = pointer_q;
        go_cnt_d  = go_cnt_q;
        eng_go_d  = 1'b0;
        done_d    = 4'b0000;
        ack_d     = ack_q;
`ifdef I2C_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A busy engine (END_OK low) blocks new grants; REQ is a level,
                // so pending requests are simply seen again later.
                if (pick_valid_s && ENG_END_OK) begin
                    state_d   = ST_GO_HI;
                    idx_d     = pick_idx_s;
                    grant_d   = 4'b0001 << pick_idx_s;
                    slave_d   = REQ_SLAVE[8*pick_idx_s +: 8];
                    pointer_d = REQ_POINTER[8*pick_idx_s +: 8];
                    go_cnt_d  = 8'd1;
                    eng_go_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GO_HI: begin
                // go_cnt_q counts the ENG_GO-high cycles already under way.
                if (go_cnt_q >= GO_HOLD_C) begin
                    state_d  = ST_GO_LO;
                    eng_go_d = 1'b0;
                end else begin
                    go_cnt_d = go_cnt_q + 8'd1;
                    eng_go_d = 1'b1;
                end
            end
            ST_GO_LO: begin
                state_d = ST_WAIT_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
                wait_cnt_d = 16'd0;
`endif
            end
            ST_WAIT_BUSY: begin
                if (!ENG_END_OK) begin
                    state_d = ST_WAIT_END;
`ifdef I2C_ARB_TIMEOUT_EN
                    wait_cnt_d = 16'd0;
                end else if (expire_s) begin
                    state_d = ST_FINISH;
                    done_d  = grant_q;
                    ack_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`else
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
`endif
            end
            ST_WAIT_END: begin
                if (ENG_END_OK) begin
                    state_d = ST_FINISH;
                    done_d  = grant_q;
                    ack_d   = ENG_ACK_OK;
`ifdef I2C_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (expire_s) begin
                    state_d = ST_FINISH;
                    done_d  = grant_q;
                    ack_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`else
                end else begin
                    state_d = ST_WAIT_END;
                end
`endif
            end
            ST_FINISH: begin
                // DONE is high during this cycle; ownership is released here.
                // No grant is issued until the following IDLE cycle.
                grant_d = 4'b0000;
                rr_d    = idx_q + 2'd1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // FSM state and registered outputs; reset abandons any transaction.
    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            grant_q   <= 4'b0000;
            idx_q     <= 2'd0;
            rr_q      <= 2'd0;
            slave_q   <= 8'd0;
            pointer_q <= 8'd0;
            go_cnt_q  <= 8'd0;
            eng_go_q  <= 1'b0;
            done_q    <= 4'b0000;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            rr_q      <= rr_d;
            slave_q   <= slave_d;
            pointer_q <= pointer_d;
            go_cnt_q  <= go_cnt_d;
            eng_go_q  <= eng_go_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog counter and timeout flag.
    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            wait_cnt_q <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign DONE        = done_q;
    assign ACK         = ack_q;
    assign GRANT       = grant_q;
    assign ENG_GO      = eng_go_q;
    assign ENG_SLAVE   = slave_q;
    assign ENG_POINTER = pointer_q;

endmodule

// File: tb/tb_i2c_pointer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_pointer_arbiter
//
// Directed test of i2c_pointer_arbiter with GO_HOLD=4 and TIMEOUT_CYC=100.
// The bench plays the engine: it lowers ENG_END_OK after GO and raises it
// later with the chosen ACK value. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_i2c_pointer_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_slave;
    logic [31:0] req_pointer;
    logic [3:0]  done;
    logic        ack;
    logic        err;
    logic [3:0]  grant;
    logic        eng_go;
    logic [7:0]  eng_slave;
    logic [7:0]  eng_pointer;
    logic        eng_end_ok;
    logic        eng_ack_ok;

    int total;
    int bad;

    logic [7:0] slv_tab [4];
    logic [7:0] ptr_tab [4];

    i2c_pointer_arbiter #(
        .GO_HOLD     (4),
        .TIMEOUT_CYC (100)
    ) dut (
        .PT_CK       (clk),
        .RESET_N     (rst_n),
        .REQ         (req),
        .REQ_SLAVE   (req_slave),
        .REQ_POINTER (req_pointer),
        .DONE        (done),
        .ACK         (ack),
        .ERR         (err),
        .GRANT       (grant),
        .ENG_GO      (eng_go),
        .ENG_SLAVE   (eng_slave),
        .ENG_POINTER (eng_pointer),
        .ENG_END_OK  (eng_end_ok),
        .ENG_ACK_OK  (eng_ack_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for ENG_GO to go high, allowing at most 20 cycles.
    task automatic wait_go();
        for (int i = 0; i < 20; i++) begin
            if (eng_go === 1'b1) break;
            @(negedge clk);
        end
        chk("go_seen", {31'd0, eng_go}, 32'd1);
    endtask

    // Count the ENG_GO-high cycles, starting from a falling edge where it is high.
    task automatic measure_go(output int len);
        len = 0;
        for (int i = 0; i < 300; i++) begin
            if (eng_go !== 1'b1) break;
            len++;
            @(negedge clk);
        end
    endtask

    // Wait for a DONE pulse, allowing at most `lim` falling edges.
    task automatic wait_done(input int lim, output int n);
        n = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            n++;
            if (done !== 4'b0000) break;
        end
    endtask

    // Run one full engine transaction and check it.
    task automatic do_txn(input logic [3:0] exp_grant, input logic [7:0] exp_sl,
                          input logic [7:0] exp_pt, input logic ack_val,
                          input logic [3:0] next_req);
        int len;
        int n;
        wait_go();
        chk("grant", {28'd0, grant}, {28'd0, exp_grant});
        chk("eng_slave", {24'd0, eng_slave}, {24'd0, exp_sl});
        chk("eng_pointer", {24'd0, eng_pointer}, {24'd0, exp_pt});
        measure_go(len);
        chk("go_len", len, 32'd4);
        eng_end_ok = 1'b0;
        repeat (3) @(negedge clk);
        chk("grant_stable", {28'd0, grant}, {28'd0, exp_grant});
        chk("no_early_done", {28'd0, done}, 32'd0);
        eng_end_ok = 1'b1;
        eng_ack_ok = ack_val;
        wait_done(10, n);
        chk("done", {28'd0, done}, {28'd0, exp_grant});
        chk("ack", {31'd0, ack}, {31'd0, ack_val});
        chk("err", {31'd0, err}, 32'd0);
        req = next_req;
        @(negedge clk);
        chk("done_one_cycle", {28'd0, done}, 32'd0);
        chk("grant_cleared", {28'd0, grant}, 32'd0);
        chk("ack_hold", {31'd0, ack}, {31'd0, ack_val});
    endtask

    initial begin
        int n;
        int len;
        int dcount;
        logic [1:0] k;
        total = 0;
        bad   = 0;
        slv_tab[0] = 8'hB2; slv_tab[1] = 8'hA0; slv_tab[2] = 8'hC4; slv_tab[3] = 8'hD6;
        ptr_tab[0] = 8'h11; ptr_tab[1] = 8'h05; ptr_tab[2] = 8'h2A; ptr_tab[3] = 8'h3F;
        req_slave   = 32'hD6C4A0B2;
        req_pointer = 32'h3F2A0511;
        rst_n      = 1'b0;
        req        = 4'b0000;
        eng_end_ok = 1'b1;
        eng_ack_ok = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_done", {28'd0, done}, 32'd0);
        chk("rst_go", {31'd0, eng_go}, 32'd0);
        chk("rst_ack_err", {30'd0, ack, err}, 32'd0);
        chk("rst_eng_addr", {16'd0, eng_slave, eng_pointer}, 32'd0);
        rst_n = 1'b1;

        // Single request from requester 1, acked
        req = 4'b0010;
        do_txn(4'b0010, 8'hA0, 8'h05, 1'b1, 4'b0000);

        // NACK from requester 0
        req = 4'b0001;
        do_txn(4'b0001, 8'hB2, 8'h11, 1'b0, 4'b0000);

        // Requester 3 moves the round-robin pointer back to 0
        req = 4'b1000;
        do_txn(4'b1000, 8'hD6, 8'h3F, 1'b1, 4'b0000);

        // Fairness: all four requesters held for 8 transactions
        req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            k = 2'(t);
            do_txn(4'b0001 << k, slv_tab[k], ptr_tab[k], 1'b1,
                   (t == 7) ? 4'b0000 : 4'b1111);
        end

        // Engine stuck with END_OK high after GO
        req = 4'b0010;
        wait_go();
        chk("stuck_grant", {28'd0, grant}, 32'h2);
        measure_go(len);
`ifdef I2C_ARB_TIMEOUT_EN
        wait_done(300, n);
        chk("timeout_latency", n, 32'd101);
        chk("timeout_done", {28'd0, done}, 32'h2);
        chk("timeout_err", {31'd0, err}, 32'd1);
        chk("timeout_ack", {31'd0, ack}, 32'd0);
        req = 4'b0000;
        @(negedge clk);
        chk("timeout_err_hold", {31'd0, err}, 32'd1);
`else
        dcount = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done !== 4'b0000) dcount++;
        end
        chk("stuck_no_done", dcount, 32'd0);
        chk("stuck_grant_held", {28'd0, grant}, 32'h2);
        eng_end_ok = 1'b0;
        repeat (2) @(negedge clk);
        eng_end_ok = 1'b1;
        eng_ack_ok = 1'b1;
        wait_done(10, n);
        chk("stuck_done", {28'd0, done}, 32'h2);
        chk("stuck_err", {31'd0, err}, 32'd0);
        req = 4'b0000;
        @(negedge clk);
`endif

        // Reset during WAIT_END
        req = 4'b0100;
        wait_go();
        chk("rst_txn_grant", {28'd0, grant}, 32'h4);
        measure_go(len);
        eng_end_ok = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = 4'b0001;
        #1;
        chk("async_rst_outs", {grant, done, 2'b00, ack, err, eng_go}, 32'd0);
        chk("async_rst_addr", {16'd0, eng_slave, eng_pointer}, 32'd0);
        dcount = 0;
        repeat (2) begin
            @(negedge clk);
            if (done !== 4'b0000) dcount++;
        end
        rst_n = 1'b1;
        // The engine is still busy: no grant yet
        repeat (3) begin
            @(negedge clk);
            if (done !== 4'b0000) dcount++;
        end
        chk("rst_no_done", dcount, 32'd0);
        chk("busy_no_grant", {27'd0, grant, eng_go}, 32'd0);
        eng_end_ok = 1'b1;
        eng_ack_ok = 1'b1;
        do_txn(4'b0001, 8'hB2, 8'h11, 1'b1, 4'b0000);

        // Busy at idle: hold off until END_OK, then grant within one cycle
        eng_end_ok = 1'b0;
        req = 4'b0100;
        repeat (5) @(negedge clk);
        chk("busy_idle_go", {31'd0, eng_go}, 32'd0);
        chk("busy_idle_grant", {28'd0, grant}, 32'd0);
        eng_end_ok = 1'b1;
        @(negedge clk);
        chk("release_grant", {28'd0, grant}, 32'h4);
        chk("release_go", {31'd0, eng_go}, 32'd1);
        do_txn(4'b0100, 8'hC4, 8'h2A, 1'b1, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
